multicycle_ctrl_fsm: RTL

//  Parametrised multicycle controller for the 16-bit datapath: FETCH/DECODE/EXECUTE/MEM/WB sequencing.

---
 rtl/cpu_ctrl_pkg.sv | 98 +++++++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_ctrl_fsm.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, funcs, ALUOp,
// ALUSrcB selects, state codes and the opcode decode helpers.
`timescale 1ns/1ps
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_SHIFT = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h1;
    localparam logic [3:0] OP_SW    = 4'h2;
    localparam logic [3:0] OP_JMP   = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNQ   = 4'h5;
    localparam logic [3:0] OP_ORI   = 4'h6;
    localparam logic [3:0] OP_NANDI = 4'h7;
    localparam logic [3:0] OP_ADD   = 4'h8;
    localparam logic [3:0] OP_ADDI1 = 4'h9;
    localparam logic [3:0] OP_ADDI2 = 4'hA;
    localparam logic [3:0] OP_NAND  = 4'hB;
    localparam logic [3:0] OP_SUB   = 4'hC;
    localparam logic [3:0] OP_SUBI1 = 4'hD;
    localparam logic [3:0] OP_SUBI2 = 4'hE;
    localparam logic [3:0] OP_OR    = 4'hF;

    localparam logic [3:0] FN_SLL = 4'h1;
    localparam logic [3:0] FN_SRL = 4'h2;
    localparam logic [3:0] FN_SRA = 4'h3;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NAND = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_SRA  = 3'b110;

    localparam logic [2:0] SRCB_B   = 3'b000;
    localparam logic [2:0] SRCB_ONE = 3'b001;
    localparam logic [2:0] SRCB_IMM = 3'b010;
    localparam logic [2:0] SRCB_OFS = 3'b011;
    localparam logic [2:0] SRCB_JT  = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EX_ALU = 4'd2,
        S_WB_ALU = 4'd3,
        S_EX_BR  = 4'd4,
        S_EX_JMP = 4'd5,
        S_EX_MEM = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_MEM = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    function automatic state_t decode_next(input logic [3:0] op,
                                           input logic [3:0] fn);
        state_t r;
        r = S_TRAP;
        case (op)
            OP_SHIFT:
                r = (fn inside {FN_SLL, FN_SRL, FN_SRA}) ? S_EX_ALU : S_TRAP;
            OP_ADD, OP_ADDI1, OP_ADDI2, OP_SUB, OP_SUBI1, OP_SUBI2,
            OP_NAND, OP_NANDI, OP_OR, OP_ORI:
                r = S_EX_ALU;
            OP_BEQ, OP_BNQ: r = S_EX_BR;
            OP_JMP:         r = S_EX_JMP;
            OP_LW, OP_SW:   r = S_EX_MEM;
            default:        r = S_TRAP;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [3:0] op,
                                             input logic [3:0] fn);
        logic [2:0] r;
        r = ALU_ADD;
        case (op)
            OP_SUB, OP_SUBI1, OP_SUBI2: r = ALU_SUB;
            OP_NAND, OP_NANDI:          r = ALU_NAND;
            OP_OR, OP_ORI:              r = ALU_OR;
            OP_SHIFT: begin
                case (fn)
                    FN_SRL:  r = ALU_SRL;
                    FN_SRA:  r = ALU_SRA;
                    default: r = ALU_SLL;
                endcase
            end
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    function automatic logic is_imm(input logic [3:0] op);
        return op inside {OP_SHIFT, OP_ADDI1, OP_ADDI2, OP_SUBI1,
                          OP_SUBI2, OP_NANDI, OP_ORI};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts non-ready cycles in a memory wait state; flags the cycle
// whose miss would exhaust the MEM_TIMEOUT budget.
`timescale 1ns/1ps
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_en,
    input  logic mem_ready,
    output logic timeout
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!wait_en || mem_ready) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A ready in the final cycle still completes the access.
    assign timeout = wait_en && !mem_ready &&
                     (cnt == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle controller for the 16-bit datapath: fetch/decode/execute/
// mem/wb sequencing with memory wait timeout and sticky traps.
`timescale 1ns/1ps
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int FUNC_W      = 4,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func_field,
    input  logic                mem_ready,
    output logic [1:0]          PCSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                sign_extend,
    output logic                ALUSrcA,
    output logic [2:0]          ALUSrcB,
    output logic [1:0]          ReadR1,
    output logic                ReadR2,
    output logic                RegWriteDst,
    output logic                MemToReg,
    output logic                PCBEqCond,
    output logic                PCBNqCond,
    output logic                PCWrite,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                WriteA,
    output logic                WriteB,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [3:0]          state_o
);

    state_t     state;
    state_t     dec_next;
    logic [3:0] op4;
    logic [3:0] fn4;
    logic       wait_en;
    logic       timeout;

    assign op4      = 4'(opcode);
    assign fn4      = 4'(func_field);
    assign dec_next = decode_next(op4, fn4);
    assign wait_en  = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign state_o  = state;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .wait_en  (wait_en),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (mem_ready) begin
                        state <= (state == S_FETCH)  ? S_DECODE :
                                 (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                    end else if (timeout) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state <= dec_next;
                    if (dec_next == S_TRAP) illegal_op <= 1'b1;
                end
                S_EX_ALU: state <= S_WB_ALU;
                S_EX_MEM: state <= (op4 == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_WB_ALU, S_EX_BR, S_EX_JMP, S_WB_MEM: state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        PCSrc       = 2'b00;
        ALUOp       = '0;
        sign_extend = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ReadR1      = 2'b00;
        ReadR2      = 1'b0;
        RegWriteDst = 1'b0;
        MemToReg    = 1'b0;
        PCBEqCond   = 1'b0;
        PCBNqCond   = 1'b0;
        PCWrite     = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        WriteA      = 1'b0;
        WriteB      = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_ONE;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                WriteA = 1'b1;
                WriteB = 1'b1;
            end
            S_EX_ALU: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(alu_op_of(op4, fn4));
                ALUSrcB     = is_imm(op4) ? SRCB_IMM : SRCB_B;
                sign_extend = op4 inside {OP_ADDI1, OP_SUBI1, OP_ORI};
            end
            S_WB_ALU: begin
                RegWrite    = 1'b1;
                RegWriteDst = 1'b1;
            end
            S_EX_BR: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALUOP_W'(ALU_SUB);
                ReadR1    = 2'b01;
                PCBEqCond = (op4 == OP_BEQ);
                PCBNqCond = (op4 == OP_BNQ);
            end
            S_EX_JMP: begin
                PCSrc   = 2'b01;
                ALUSrcB = SRCB_JT;
                PCWrite = 1'b1;
            end
            S_EX_MEM: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_OFS;
                sign_extend = 1'b1;
                ReadR1      = 2'b10;
                ReadR2      = 1'b1;
            end
            S_MEM_RD: MemRead = 1'b1;
            S_MEM_WR: begin
                MemWrite = 1'b1;
                ReadR2   = 1'b1;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
